// File: rtl/packet_length_meter_if.sv
// Stream-tap and result bundle for packet_length_meter.
// The master drives the observed stream; the slave (the meter) returns per-packet results.
interface packet_length_meter_if #(
    parameter int KEEP_WIDTH        = 8,
    parameter int QUEUE_ID_WIDTH    = 1,
    parameter int PACKET_SIZE_WIDTH = 16
);
    logic                         s_valid_i;
    logic                         s_ready_i;
    logic [KEEP_WIDTH-1:0]        s_keep_i;
    logic                         s_last_i;
    logic                         s_err_i;
    logic [QUEUE_ID_WIDTH-1:0]    q_id_i;

    logic [QUEUE_ID_WIDTH-1:0]    c_id_o;
    logic [PACKET_SIZE_WIDTH-1:0] p_len_o;
    logic                         count_o;
    logic [31:0]                  drop_cnt_o;
    logic [31:0]                  oversize_cnt_o;

    modport master (
        output s_valid_i, s_ready_i, s_keep_i, s_last_i, s_err_i, q_id_i,
        input  c_id_o, p_len_o, count_o, drop_cnt_o, oversize_cnt_o
    );

    modport slave (
        input  s_valid_i, s_ready_i, s_keep_i, s_last_i, s_err_i, q_id_i,
        output c_id_o, p_len_o, count_o, drop_cnt_o, oversize_cnt_o
    );
endinterface

// File: rtl/packet_length_meter.sv
// Passive stream tap: sums bytes per packet from the keep popcount and reports length,
// queue id, aborted-packet count and saturated-length count, all from registers.
module packet_length_meter #(
    parameter int KEEP_WIDTH        = 8,
    parameter int QUEUE_ID_WIDTH    = 1,
    parameter int PACKET_SIZE_WIDTH = 16
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    packet_length_meter_if.slave  s
);
    localparam int PC_W  = $clog2(KEEP_WIDTH + 1);
    // One spare bit above the wider operand so an overflowing sum is still visible.
    localparam int SUM_W = ((PACKET_SIZE_WIDTH > PC_W) ? PACKET_SIZE_WIDTH : PC_W) + 1;
    localparam logic [SUM_W-1:0] LEN_MAX = SUM_W'({PACKET_SIZE_WIDTH{1'b1}});

    typedef enum logic {IDLE, IN_PKT} state_e;

    state_e                       state_q, state_d;
    logic [PACKET_SIZE_WIDTH-1:0] acc_q, acc_d;
    logic                         ovf_q, ovf_d;
    logic [QUEUE_ID_WIDTH-1:0]    id_q, id_d;
    logic                         count_q, count_d;
    logic [QUEUE_ID_WIDTH-1:0]    c_id_q, c_id_d;
    logic [PACKET_SIZE_WIDTH-1:0] p_len_q, p_len_d;
    logic [31:0]                  drop_q, drop_d;
    logic [31:0]                  ovs_q, ovs_d;

    logic                         beat;
    logic                         first;
    logic [SUM_W-1:0]             sum;
    logic                         sat;
    logic [PACKET_SIZE_WIDTH-1:0] len_new;
    logic                         ovf_new;
    logic [QUEUE_ID_WIDTH-1:0]    id_new;

    function automatic logic [SUM_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) n = n + SUM_W'(k[i]);
        return n;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign beat    = s.s_valid_i & s.s_ready_i;
    assign first   = (state_q == IDLE);
    assign sum     = (first ? '0 : SUM_W'(acc_q)) + popcount(s.s_keep_i);
    assign sat     = (sum > LEN_MAX);
    assign len_new = sat ? {PACKET_SIZE_WIDTH{1'b1}} : sum[PACKET_SIZE_WIDTH-1:0];
    assign ovf_new = sat | (~first & ovf_q);
    assign id_new  = first ? s.q_id_i : id_q;

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        id_d    = id_q;
        count_d = 1'b0;
        c_id_d  = c_id_q;
        p_len_d = p_len_q;
        drop_d  = drop_q;
        ovs_d   = ovs_q;

        if (beat) begin
            acc_d = len_new;
            ovf_d = ovf_new;
            id_d  = id_new;
            if (s.s_last_i) begin
                state_d = IDLE;
                if (s.s_err_i) begin
                    drop_d = sat_inc(drop_q);
                end else begin
                    count_d = 1'b1;
                    c_id_d  = id_new;
                    p_len_d = len_new;
                end
                if (ovf_new) ovs_d = sat_inc(ovs_q);
            end else begin
                state_d = IN_PKT;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
            count_q <= 1'b0;
            c_id_q  <= '0;
            p_len_q <= '0;
            drop_q  <= '0;
            ovs_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
            count_q <= count_d;
            c_id_q  <= c_id_d;
            p_len_q <= p_len_d;
            drop_q  <= drop_d;
            ovs_q   <= ovs_d;
        end
    end

    assign s.count_o        = count_q;
    assign s.c_id_o         = c_id_q;
    assign s.p_len_o        = p_len_q;
    assign s.drop_cnt_o     = drop_q;
    assign s.oversize_cnt_o = ovs_q;
endmodule

// File: doc/packet_length_meter.md
PACKET_LENGTH_METER -- requirements
Module: packet_length_meter

Interface
REQ-001 SHALL have parameter KEEP_WIDTH, default 8, meaning bytes per data beat (data bus is 8*KEEP_WIDTH bits).
REQ-002 SHALL have parameter QUEUE_ID_WIDTH, default 1, meaning width of queue/counter id.
REQ-003 SHALL have parameter PACKET_SIZE_WIDTH, default 16, meaning width of emitted packet byte length.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port s_valid_i  input  1  beat valid on the observed stream (passive tap).
REQ-007 SHALL have port s_ready_i  input  1  beat accepted by the stream sink; a beat counts only when s_valid_i and s_ready_i are both 1.
REQ-008 SHALL have port s_keep_i  input  KEEP_WIDTH  byte-enable of current beat.
REQ-009 SHALL have port s_last_i  input  1  final beat of packet.
REQ-010 SHALL have port s_err_i  input  1  packet-abort flag, sampled on the last beat.
REQ-011 SHALL have port q_id_i  input  QUEUE_ID_WIDTH  destination queue id, sampled on the first beat.
REQ-012 SHALL have port c_id_o  output  QUEUE_ID_WIDTH  queue id of the completed packet.
REQ-013 SHALL have port p_len_o  output  PACKET_SIZE_WIDTH  byte length of the completed packet.
REQ-014 SHALL have port count_o  output  1  one-cycle pulse qualifying c_id_o/p_len_o; no back-pressure.
REQ-015 SHALL have port drop_cnt_o  output  32  saturating count of aborted packets.
REQ-016 SHALL have port oversize_cnt_o  output  32  saturating count of packets whose length saturated.

Function
REQ-017 SHALL implement states IDLE (awaiting first beat) and IN_PKT (between first and last beat).
REQ-018 SHALL, on an accepted beat in IDLE, capture q_id_i and load the accumulator with popcount(s_keep_i); if s_last_i is also 1, SHALL complete the packet and remain in IDLE, else go to IN_PKT.
REQ-019 SHALL, on an accepted beat in IN_PKT, add popcount(s_keep_i) to the accumulator and ignore q_id_i; with s_last_i=1, SHALL complete the packet and go to IDLE.
REQ-020 SHALL ignore all inputs on cycles where s_valid_i and s_ready_i are not both 1; state and accumulator hold.
REQ-021 SHALL count set keep bits by popcount regardless of contiguity; a beat with s_keep_i=0 adds 0.
REQ-022 SHALL saturate the accumulator at 2^PACKET_SIZE_WIDTH-1; a packet that saturated at any point SHALL be flagged oversize.
REQ-023 SHALL, on completion with s_err_i=0, assert count_o for exactly one cycle, the cycle after the last beat, with c_id_o and p_len_o equal to the captured id and final length (including the last beat's bytes).
REQ-024 SHALL, on completion with s_err_i=1, not assert count_o and increment drop_cnt_o the cycle after the last beat.
REQ-025 SHALL increment oversize_cnt_o the cycle after completion of an oversize packet, whether or not s_err_i=1; an oversize non-aborted packet SHALL still pulse count_o with the saturated length.
REQ-026 SHALL sustain back-to-back packets, including consecutive single-beat packets, producing count_o on consecutive cycles with no lost packet.
REQ-027 SHALL hold c_id_o and p_len_o stable at their last emitted values while count_o=0.
REQ-028 SHALL saturate drop_cnt_o and oversize_cnt_o at 32'hFFFFFFFF without wrap.
REQ-029 SHALL have zero combinational paths from inputs to outputs; all outputs registered.

Reset
REQ-030 SHALL, while rst_n_i=0, immediately force state IDLE, accumulator 0, count_o 0, c_id_o 0, p_len_o 0, drop_cnt_o 0, oversize_cnt_o 0.
REQ-031 SHALL discard a packet in progress when reset asserts; the first accepted beat after release SHALL be treated as a first beat.
REQ-032 SHALL deassert reset internally in a way that the first clock edge after rst_n_i rises already accepts beats.

Verification
REQ-033 Single beat keep=8'h3F, q_id=1, last=1 -> next cycle count_o=1, c_id_o=1, p_len_o=6.
REQ-034 Three beats keep FF,FF,0F, q_id=0 on beat 1 and 1 on beats 2-3, s_ready_i low one cycle mid-packet -> one pulse, c_id_o=0, p_len_o=20.
REQ-035 Packet of 2 beats keep FF,FF with s_err_i=1 on last -> no count_o, drop_cnt_o 0->1.
REQ-036 PACKET_SIZE_WIDTH=4, 3 full beats (24 bytes) -> count_o with p_len_o=15, oversize_cnt_o=1.
REQ-037 Four consecutive single-beat packets keep 01,03,07,0F, ids 0,1,0,1 -> four consecutive pulses, lengths 1,2,3,4, ids 0,1,0,1.
REQ-038 rst_n_i low for one cycle after beat 1 of a 2-beat packet, then fresh single beat keep=FF -> outputs zero during reset, then one pulse p_len_o=8.
